// File: rtl/wb_data_ram.sv
// wb_data_ram
// Single-port Wishbone (classic, non-pipelined) data RAM of DEPTH_WORDS 32-bit
// words located at BASE_ADDR. Each request is latched on accept, optionally
// held for WAIT_STATES idle cycles, then answered with a one-cycle ACK (in
// range) or ERR (out of range). Byte lanes are not supported: every transfer
// is a full word and ADR[1:0] is ignored.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, 16..65536)
//   BASE_ADDR   : byte address of word 0 (aligned to DEPTH_WORDS*4)
//   WAIT_STATES : idle cycles between accept and response (0..15)
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   reset, active-low, asynchronous assert / synchronous release
//   CYC    in   bus cycle valid
//   STB    in   request strobe
//   WE     in   1 = write, 0 = read
//   ADR    in   [31:0] byte address
//   DAT_I  in   [31:0] write data
//   DAT_O  out  [31:0] read data, zero outside a read ACK cycle
//   ACK    out  one-cycle transfer-complete pulse
//   ERR    out  one-cycle address-error pulse
module wb_data_ram #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CYC,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] ADR,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic        ERR
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    wcnt;
    logic          rdy;
    logic          req;
    logic          accept;
    logic [31:0]   off;
    logic          hit;

    logic [AW-1:0] idx_p0;
    logic          we_p0;
    logic          hit_p0;
    logic [31:0]   dat_p0;

    logic [31:0]   mem [DEPTH_WORDS];

    assign req    = CYC & STB;
    // rdy is cleared by reset and set on the first edge after release, so the
    // earliest accept is the second rising edge after rst returns high.
    assign accept = (state == IDLE) && rdy && req;

    // Offset from the window base; wrap-around of the subtraction makes any
    // address below BASE_ADDR compare as a large unsigned value, i.e. miss.
    assign off = ADR - BASE_ADDR;
    assign hit = (off < SPAN);

    // Control: FSM, wait counter and post-reset ready flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            wcnt  <= 4'd0;
            rdy   <= 1'b0;
        end else begin
            rdy <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= (WAIT_STATES > 0) ? WAIT : RESP;
                        wcnt  <= WS_LOAD;
                    end
                end
                WAIT: begin
                    // Master withdrew the request: drop it silently.
                    if (!req) begin
                        state <= IDLE;
                        wcnt  <= 4'd0;
                    end else if (wcnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                RESP: begin
                    // Response is committed; CYC/STB are not consulted here.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    wcnt  <= 4'd0;
                end
            endcase
        end
    end

    // Stage p0: request latched at accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p0 <= off[AW+1:2];
            we_p0  <= WE;
            hit_p0 <= hit;
            dat_p0 <= DAT_I;
        end
    end

    // Memory write on the RESP edge; reset forces state to IDLE, so an
    // interrupted write never reaches this point.
    always_ff @(posedge clk) begin
        if ((state == RESP) && we_p0 && hit_p0) begin
            mem[idx_p0] <= dat_p0;
        end
    end

    // Outputs decode directly from the reset-cleared state register, so
    // asserting rst forces them low without waiting for a clock edge.
    assign ACK   = (state == RESP) && hit_p0;
    assign ERR   = (state == RESP) && !hit_p0;
    assign DAT_O = ((state == RESP) && hit_p0 && !we_p0) ? mem[idx_p0] : 32'd0;

endmodule

// File: tb/tb_wb_data_ram.sv
// tb_wb_data_ram
// Two instances of wb_data_ram share clock and reset: dev 0 with no wait
// states and dev 1 with three. Directed transfers push their expected
// response (kind, data, arrival cycle) into a per-device queue; a monitor on
// the falling edge pops and compares whenever ACK or ERR is seen, and checks
// that DAT_O stays zero in every other cycle.
module tb_wb_data_ram;

    typedef struct {
        bit          is_err;
        bit          is_rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic [1:0]  we;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] adr   [2];
    logic [31:0] dat_i [2];
    logic [31:0] dat_o [2];

    int   cyc_cnt;
    int   n_tests;
    int   n_fail;
    exp_t q0 [$];
    exp_t q1 [$];

    wb_data_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dev0 (
        .clk(clk), .rst(rst), .CYC(cyc[0]), .STB(stb[0]), .WE(we[0]),
        .ADR(adr[0]), .DAT_I(dat_i[0]), .DAT_O(dat_o[0]), .ACK(ack[0]), .ERR(err[0])
    );

    wb_data_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dev1 (
        .clk(clk), .rst(rst), .CYC(cyc[1]), .STB(stb[1]), .WE(we[1]),
        .ADR(adr[1]), .DAT_I(dat_i[1]), .DAT_O(dat_o[1]), .ACK(ack[1]), .ERR(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dev%0d: got %h, expected %h (t=%0t)", nm, d, got, exp, $time);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic check_dev(input int d);
        exp_t e;
        bit   have;
        chk("ack_err_excl", d, {31'd0, ack[d] & err[d]}, 32'd0);
        if (ack[d] | err[d]) begin
            have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
            if (!have) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp dev%0d: got ack=%0b err=%0b, expected no response (t=%0t)",
                         d, ack[d], err[d], $time);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk("resp_is_err", d, {31'd0, err[d]}, {31'd0, e.is_err});
                chk("resp_cycle", d, cyc_cnt, e.cyc);
                chk("resp_data", d, dat_o[d], (e.is_rd && !e.is_err) ? e.data : 32'd0);
            end
        end else begin
            chk("idle_dat_o", d, dat_o[d], 32'd0);
        end
    endtask

    always @(negedge clk) begin
        check_dev(0);
        check_dev(1);
    end

    // Waits (bounded) for ACK/ERR on device d, observed at a falling edge.
    task automatic wait_resp(input int d);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack[d] | err[d]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout dev%0d: got no ACK/ERR in 40 cycles, expected one", d);
        end
    endtask

    // One transfer. b2b = 1 means the caller is at the previous RESP falling
    // edge, so the request is refused on that RESP edge and accepted one later.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input bit exp_err, input logic [31:0] exp_rd, input bit b2b);
        exp_t e;
        if (!b2b) @(negedge clk);
        cyc[d]   = 1'b1;
        stb[d]   = 1'b1;
        we[d]    = w;
        adr[d]   = a;
        dat_i[d] = wd;
        e.is_err = exp_err;
        e.is_rd  = !w;
        e.data   = exp_rd;
        e.cyc    = cyc_cnt + (b2b ? 2 : 1) + ws(d);
        push(d, e);
        wait_resp(d);
        cyc[d] = 1'b0;
        stb[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        n_tests = 0;
        n_fail  = 0;
        cyc = '0; stb = '0; we = '0;
        for (int i = 0; i < 2; i++) begin
            adr[i]   = '0;
            dat_i[i] = '0;
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ack", i, {31'd0, ack[i]}, 32'd0);
            chk("rst_err", i, {31'd0, err[i]}, 32'd0);
            chk("rst_dat_o", i, dat_o[i], 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Zero wait states: basic write/read, range, misalignment, back-to-back.
        xfer(0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0);
        xfer(0, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0);
        xfer(0, 1, 32'h0, 32'h11111111, 0, 32'h0, 0);
        xfer(0, 1, 32'h1000, 32'h99999999, 1, 32'h0, 0);
        xfer(0, 0, 32'h0, 32'h0, 0, 32'h11111111, 0);
        xfer(0, 0, 32'h1000, 32'h0, 1, 32'h0, 0);
        xfer(0, 1, 32'hFFC, 32'hCAFEF00D, 0, 32'h0, 0);
        xfer(0, 0, 32'hFFC, 32'h0, 0, 32'hCAFEF00D, 0);
        xfer(0, 0, 32'hFFFFFFFC, 32'h0, 1, 32'h0, 0);
        xfer(0, 1, 32'h4, 32'h0, 0, 32'h0, 0);
        xfer(0, 1, 32'h7, 32'hA5A5A5A5, 0, 32'h0, 0);
        xfer(0, 0, 32'h4, 32'h0, 0, 32'hA5A5A5A5, 0);
        xfer(0, 1, 32'h14, 32'h0BADF00D, 0, 32'h0, 0);
        xfer(0, 0, 32'h14, 32'h0, 0, 32'h0BADF00D, 1);
        xfer(0, 1, 32'h14, 32'h600DCAFE, 0, 32'h0, 1);
        xfer(0, 0, 32'h16, 32'h0, 0, 32'h600DCAFE, 1);

        // Three wait states.
        xfer(1, 1, 32'h0, 32'h44444444, 0, 32'h0, 0);
        xfer(1, 0, 32'h0, 32'h0, 0, 32'h44444444, 0);
        xfer(1, 1, 32'h20, 32'h22222222, 0, 32'h0, 0);
        xfer(1, 1, 32'h1000, 32'h77777777, 1, 32'h0, 0);
        xfer(1, 0, 32'h20, 32'h0, 0, 32'h22222222, 1);

        // Abort: STB dropped in the second WAIT cycle of a write.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        adr[1] = 32'h20; dat_i[1] = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        stb[1] = 1'b0;
        repeat (6) @(negedge clk);
        cyc[1] = 1'b0;
        xfer(1, 0, 32'h20, 32'h0, 0, 32'h22222222, 0);

        // Reset during WAIT of a write: outputs clear at once, memory unchanged.
        xfer(1, 1, 32'h30, 32'h33333333, 0, 32'h0, 0);
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        adr[1] = 32'h30; dat_i[1] = 32'hFFFF0000;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("wait_rst_ack", 1, {31'd0, ack[1]}, 32'd0);
        chk("wait_rst_err", 1, {31'd0, err[1]}, 32'd0);
        chk("wait_rst_dat_o", 1, dat_o[1], 32'd0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        xfer(1, 0, 32'h30, 32'h0, 0, 32'h33333333, 0);

        // Reset in a read RESP cycle: ACK and DAT_O drop before any edge.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h30;
        e.is_err = 1'b0; e.is_rd = 1'b1; e.data = 32'h33333333; e.cyc = cyc_cnt + 4;
        push(1, e);
        wait_resp(1);
        #1 rst = 1'b0;
        #1;
        chk("resp_rst_ack", 1, {31'd0, ack[1]}, 32'd0);
        chk("resp_rst_dat_o", 1, dat_o[1], 32'd0);
        repeat (2) @(negedge clk);

        // Release with the request already held: accept on the second edge.
        rst = 1'b1;
        e.is_err = 1'b0; e.is_rd = 1'b1; e.data = 32'h33333333; e.cyc = cyc_cnt + 2 + 3;
        push(1, e);
        wait_resp(1);
        cyc[1] = 1'b0; stb[1] = 1'b0;

        repeat (6) @(negedge clk);
        chk("q_drain", 0, q0.size(), 32'd0);
        chk("q_drain", 1, q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
